// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file writeback queue.
package wb_pkg;

  localparam int unsigned DEF_ADDR_W = 5;
  localparam int unsigned DEF_DATA_W = 32;

  localparam logic [DEF_ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] rd;
    logic [DEF_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer with head/tail pointers; every slot and its valid bit is
// exposed so the parent can scan pending writes for forwarding.
module wb_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 37
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             push,
  input  logic [W-1:0]                     push_data,
  input  logic                             pop,
  output logic [W-1:0]                     head_data,
  output logic [$clog2(DEPTH)-1:0]         head_idx,
  output logic [$clog2(DEPTH):0]           count,
  output logic [DEPTH-1:0][W-1:0]          slot_data,
  output logic [DEPTH-1:0]                 slot_valid
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]        head_q, head_d;
  logic [PTR_W-1:0]        tail_q, tail_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [PTR_W-1:0]        off;

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) begin
      mem_d[tail_q] = push_data;
      tail_d        = tail_q + PTR_ONE;
    end
    if (pop) begin
      head_d = head_q + PTR_ONE;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // A slot is live when its distance from head (mod DEPTH) is below count.
  always_comb begin
    slot_valid = '0;
    off        = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      off           = PTR_W'(i) - head_q;
      slot_valid[i] = (CNT_W'(off) < count_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_data = mem_q[head_q];
  assign head_idx  = head_q;
  assign count     = count_q;
  assign slot_data = mem_q;

endmodule

// File: rtl/regfile_writeback_queue.sv
// Write-side driver for the register file: ALU/MDU arbitration, in-order
// write queue, registered issue port and youngest-first forwarding to decode.
module regfile_writeback_queue
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = wb_pkg::DEF_DATA_W,
  parameter int unsigned ADDR_W = wb_pkg::DEF_ADDR_W
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic                     aluValid,
  input  logic [ADDR_W-1:0]        aluRd,
  input  logic [DATA_W-1:0]        aluData,
  input  logic                     mduValid,
  output logic                     mduReady,
  input  logic [ADDR_W-1:0]        mduRd,
  input  logic [DATA_W-1:0]        mduData,
  input  logic                     portBusy,
  output logic                     writeSig,
  output logic [ADDR_W-1:0]        rd,
  output logic [DATA_W-1:0]        writeData,
  input  logic [ADDR_W-1:0]        rs,
  input  logic [ADDR_W-1:0]        rt,
  output logic                     fwdRsHit,
  output logic                     fwdRtHit,
  output logic [DATA_W-1:0]        fwdRsData,
  output logic [DATA_W-1:0]        fwdRtData,
  output logic                     stall,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ENT_W = ADDR_W + DATA_W;
  localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ALMOST = CNT_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ZERO_IDX  = ADDR_W'(REG_ZERO);

  logic                          pop, push;
  logic                          alu_store, mdu_store, alu_drop;
  logic [ENT_W-1:0]              push_data, head_data;
  logic [PTR_W-1:0]              head_idx;
  logic [CNT_W-1:0]              fifo_count;
  logic [DEPTH-1:0][ENT_W-1:0]   slot_data;
  logic [DEPTH-1:0]              slot_valid;

  logic                          write_sig_q, write_sig_d;
  logic [ADDR_W-1:0]             rd_q, rd_d;
  logic [DATA_W-1:0]             write_data_q, write_data_d;
  logic                          overflow_q, overflow_d;

  logic [PTR_W-1:0]              idx;
  logic [ADDR_W-1:0]             ent_rd;
  logic [DATA_W-1:0]             ent_data;

  wb_fifo #(
    .DEPTH (DEPTH),
    .W     (ENT_W)
  ) u_fifo (
    .clk        (Clk),
    .rst_n      (Rst_n),
    .push       (push),
    .push_data  (push_data),
    .pop        (pop),
    .head_data  (head_data),
    .head_idx   (head_idx),
    .count      (fifo_count),
    .slot_data  (slot_data),
    .slot_valid (slot_valid)
  );

  // A full queue still accepts an ALU write when the head leaves in the same cycle.
  always_comb begin
    pop       = (fifo_count != '0) && !portBusy;
    mduReady  = !aluValid && (fifo_count < CNT_FULL);
    alu_store = aluValid && (aluRd != ZERO_IDX) && ((fifo_count < CNT_FULL) || pop);
    alu_drop  = aluValid && (aluRd != ZERO_IDX) && (fifo_count == CNT_FULL) && !pop;
    mdu_store = mduValid && mduReady && (mduRd != ZERO_IDX);
    push      = alu_store || mdu_store;
    push_data = aluValid ? {aluRd, aluData} : {mduRd, mduData};
  end

  always_comb begin
    write_sig_d  = pop;
    rd_d         = rd_q;
    write_data_d = write_data_q;
    overflow_d   = overflow_q || alu_drop;
    if (pop) begin
      rd_d         = head_data[ENT_W-1 -: ADDR_W];
      write_data_d = head_data[DATA_W-1:0];
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      write_sig_q  <= 1'b0;
      rd_q         <= '0;
      write_data_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      write_sig_q  <= write_sig_d;
      rd_q         <= rd_d;
      write_data_q <= write_data_d;
      overflow_q   <= overflow_d;
    end
  end

  // Issue register first, then queue oldest to newest: later matches override.
  always_comb begin
    fwdRsHit  = 1'b0;
    fwdRtHit  = 1'b0;
    fwdRsData = '0;
    fwdRtData = '0;
    idx       = '0;
    ent_rd    = '0;
    ent_data  = '0;
    if (write_sig_q) begin
      if (rs != ZERO_IDX && rd_q == rs) begin
        fwdRsHit  = 1'b1;
        fwdRsData = write_data_q;
      end
      if (rt != ZERO_IDX && rd_q == rt) begin
        fwdRtHit  = 1'b1;
        fwdRtData = write_data_q;
      end
    end
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx      = head_idx + PTR_W'(k);
      ent_rd   = slot_data[idx][ENT_W-1 -: ADDR_W];
      ent_data = slot_data[idx][DATA_W-1:0];
      if (slot_valid[idx]) begin
        if (rs != ZERO_IDX && ent_rd == rs) begin
          fwdRsHit  = 1'b1;
          fwdRsData = ent_data;
        end
        if (rt != ZERO_IDX && ent_rd == rt) begin
          fwdRtHit  = 1'b1;
          fwdRtData = ent_data;
        end
      end
    end
  end

  assign writeSig  = write_sig_q;
  assign rd        = rd_q;
  assign writeData = write_data_q;
  assign overflow  = overflow_q;
  assign count     = fifo_count;
  assign stall     = (fifo_count >= CNT_ALMOST);

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Directed bench for regfile_writeback_queue with a commit-order scoreboard.
module tb_regfile_writeback_queue;
  import wb_pkg::*;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        aluValid, mduValid, portBusy;
  logic [4:0]  aluRd, mduRd, rs, rt, rd;
  logic [31:0] aluData, mduData, writeData, fwdRsData, fwdRtData;
  logic        mduReady, writeSig, fwdRsHit, fwdRtHit, stall, overflow;
  logic [2:0]  count;

  int n_cmp = 0;
  int n_err = 0;
  int n_commit = 0;
  wb_entry_t exp_q[$];

  regfile_writeback_queue #(
    .DEPTH  (4),
    .DATA_W (32),
    .ADDR_W (5)
  ) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .aluValid  (aluValid),
    .aluRd     (aluRd),
    .aluData   (aluData),
    .mduValid  (mduValid),
    .mduReady  (mduReady),
    .mduRd     (mduRd),
    .mduData   (mduData),
    .portBusy  (portBusy),
    .writeSig  (writeSig),
    .rd        (rd),
    .writeData (writeData),
    .rs        (rs),
    .rt        (rt),
    .fwdRsHit  (fwdRsHit),
    .fwdRtHit  (fwdRtHit),
    .fwdRsData (fwdRsData),
    .fwdRtData (fwdRtData),
    .stall     (stall),
    .overflow  (overflow),
    .count     (count)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic expect_commit(input logic [4:0] r, input logic [31:0] d);
    wb_entry_t e;
    e.rd   = r;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Register file captures on the negedge; every commit is checked against the scoreboard there.
  always @(negedge Clk) begin
    if (Rst_n === 1'b1 && writeSig === 1'b1) begin
      n_commit++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $error("FAIL commit_unexpected observed=%0h_%0h expected=none", rd, writeData);
      end else begin
        wb_entry_t e;
        e = exp_q.pop_front();
        chk("commit", {27'd0, rd, writeData}, {27'd0, e.rd, e.data});
      end
    end
  end

  initial begin
    int c0;
    Rst_n = 1'b0; aluValid = 0; mduValid = 0; portBusy = 0;
    aluRd = '0; aluData = '0; mduRd = '0; mduData = '0; rs = '0; rt = '0;
    tick(); tick();
    chk("rst_count", count, 0);
    chk("rst_writeSig", writeSig, 0);
    chk("rst_rd", rd, 0);
    chk("rst_writeData", writeData, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_stall", stall, 0);
    Rst_n = 1'b1;
    tick();

    // Single ALU write
    aluValid = 1; aluRd = 5'd8; aluData = 32'hDEADBEEF; rs = 5'd8;
    expect_commit(5'd8, 32'hDEADBEEF);
    #1 chk("inflight_no_fwd", fwdRsHit, 0);
    tick();
    aluValid = 0;
    #1;
    chk("t1_count", count, 1);
    chk("t1_fwd_q_hit", fwdRsHit, 1);
    chk("t1_fwd_q_data", fwdRsData, 32'hDEADBEEF);
    tick();
    chk("t1_writeSig", writeSig, 1);
    chk("t1_rd", rd, 8);
    chk("t1_writeData", writeData, 32'hDEADBEEF);
    chk("t1_fwd_issue_hit", fwdRsHit, 1);
    tick();
    chk("t1_writeSig_low", writeSig, 0);
    chk("t1_fwd_gone", fwdRsHit, 0);
    chk("t1_rd_hold", rd, 8);

    // Arbitration: ALU wins, MDU accepted the next cycle
    aluValid = 1; aluRd = 5'd3; aluData = 32'd1;
    mduValid = 1; mduRd = 5'd4; mduData = 32'd2;
    expect_commit(5'd3, 32'd1);
    #1 chk("arb_mduReady_low", mduReady, 0);
    tick();
    aluValid = 0;
    #1 chk("arb_mduReady_high", mduReady, 1);
    expect_commit(5'd4, 32'd2);
    tick();
    mduValid = 0;
    repeat (4) tick();

    // Port busy: two writes to r5, youngest forwarded
    portBusy = 1;
    aluValid = 1; aluRd = 5'd5; aluData = 32'h10;
    expect_commit(5'd5, 32'h10);
    tick();
    aluData = 32'h20;
    expect_commit(5'd5, 32'h20);
    tick();
    aluValid = 0; rs = 5'd5; rt = 5'd5;
    #1;
    chk("busy_count", count, 2);
    chk("busy_fwdRsHit", fwdRsHit, 1);
    chk("busy_fwdRsData", fwdRsData, 32'h20);
    chk("busy_fwdRtData", fwdRtData, 32'h20);
    chk("busy_no_issue", writeSig, 0);
    portBusy = 0;
    repeat (4) tick();

    // Fill and overflow
    portBusy = 1;
    for (int i = 0; i < 4; i++) begin
      aluValid = 1; aluRd = 5'(10 + i); aluData = 32'hA0 + 32'(i);
      expect_commit(5'(10 + i), 32'hA0 + 32'(i));
      tick();
      if (i == 1) chk("fill_stall_at2", stall, 0);
      if (i == 2) chk("fill_stall_at3", stall, 1);
    end
    chk("fill_count4", count, 4);
    chk("fill_no_ovf_yet", overflow, 0);
    aluRd = 5'd14; aluData = 32'hFF;
    tick();
    aluValid = 0;
    #1;
    chk("ovf_set", overflow, 1);
    chk("ovf_count", count, 4);
    c0 = n_commit;
    portBusy = 0;
    repeat (7) tick();
    chk("ovf_commits", n_commit - c0, 4);
    chk("ovf_sticky", overflow, 1);

    // Zero register write is swallowed
    aluValid = 1; aluRd = 5'd0; aluData = 32'h1234; rs = 5'd0;
    tick();
    aluValid = 0;
    #1;
    chk("zero_count", count, 0);
    chk("zero_fwd", fwdRsHit, 0);
    tick();
    chk("zero_writeSig", writeSig, 0);

    // Reset mid-operation discards pending writes
    portBusy = 1;
    for (int i = 0; i < 3; i++) begin
      aluValid = 1; aluRd = 5'(20 + i); aluData = 32'(i);
      tick();
    end
    aluValid = 0;
    #1 chk("pre_rst_count", count, 3);
    Rst_n = 1'b0;
    #1;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_writeSig", writeSig, 0);
    chk("mid_rst_overflow", overflow, 0);
    tick();
    Rst_n = 1'b1;
    portBusy = 0;
    c0 = n_commit;
    repeat (6) tick();
    chk("post_rst_no_commit", n_commit - c0, 0);

    chk("sb_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
